// File: rtl/udma_adc_ch_sched_if.sv
// Bus bundle for the ADC channel scheduler: the ADC request/acknowledge
// pair and the 32-bit sample stream toward the uDMA rx channel.
interface udma_adc_ch_sched_if #(
  parameter int CH_W   = 2,
  parameter int DATA_W = 12
);
  logic              adc_req_o;
  logic [CH_W-1:0]   adc_ch_o;
  logic              adc_ack_i;
  logic [DATA_W-1:0] adc_data_i;
  logic [31:0]       data_o;
  logic              valid_o;
  logic              ready_i;

  // Scheduler side: drives requests and the sample stream
  modport master (
    output adc_req_o, adc_ch_o, data_o, valid_o,
    input  adc_ack_i, adc_data_i, ready_i
  );

  // ADC front end / uDMA side
  modport slave (
    input  adc_req_o, adc_ch_o, data_o, valid_o,
    output adc_ack_i, adc_data_i, ready_i
  );
endinterface

// File: rtl/udma_adc_ch_sched.sv
// ADC channel scan scheduler: a period counter triggers scans over the
// enabled channels in ascending order; each conversion result is packed
// with its channel index and pushed out as one 32-bit stream word.
module udma_adc_ch_sched #(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int DATA_W   = 12,
  parameter int PERIOD_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_en_i,
  input  logic [NUM_CH-1:0]   cfg_ch_mask_i,
  input  logic [PERIOD_W-1:0] cfg_period_i,
  udma_adc_ch_sched_if.master adc_if,
  output logic                busy_o,
  output logic                overrun_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SELECT,
    CONVERT,
    PUSH
  } state_t;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_cnt;
  logic [NUM_CH-1:0]   r_mask;
  logic [CH_W-1:0]     r_ch;
  logic                r_req;
  logic                r_valid;
  logic [31:0]         r_data;

  logic                w_tick;
  logic [CH_W-1:0]     w_sel_ch;
  logic [NUM_CH-1:0]   w_sel_oh;
  logic [31:0]         w_word;

  // The >= compare keeps the counter from running past a period that was
  // lowered while the count was already above it.
  assign w_tick = cfg_en_i & (r_cnt >= cfg_period_i);

  // Period counter: counts 0..cfg_period_i while enabled, cleared otherwise
  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_en_i) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PERIOD_W'(1);
    end
  end

  // Lowest-index set bit of the remaining scan mask (index and one-hot)
  always_comb begin
    w_sel_ch = '0;
    w_sel_oh = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_sel_ch    = CH_W'(i);
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
      end
    end
  end

  // Stream word: channel index at bit 16, sample right-aligned
  always_comb begin
    w_word              = '0;
    w_word[DATA_W-1:0]  = adc_if.adc_data_i;
    w_word[16 +: CH_W]  = r_ch;
  end

  // Scan FSM with registered request/stream outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_ch    <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cfg_en_i) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (!cfg_en_i) begin
            r_state <= IDLE;
          end else if (w_tick && (|cfg_ch_mask_i)) begin
            r_mask  <= cfg_ch_mask_i;
            r_state <= SELECT;
          end
        end
        SELECT: begin
          // Nothing has been requested yet, so a disable here just abandons
          if (!cfg_en_i) begin
            r_mask  <= '0;
            r_state <= IDLE;
          end else begin
            r_ch    <= w_sel_ch;
            r_mask  <= r_mask & ~w_sel_oh;
            r_req   <= 1'b1;
            r_state <= CONVERT;
          end
        end
        CONVERT: begin
          // An outstanding request always completes, even if disabled meanwhile
          if (adc_if.adc_ack_i) begin
            r_req   <= 1'b0;
            r_data  <= w_word;
            r_valid <= 1'b1;
            r_state <= PUSH;
          end
        end
        PUSH: begin
          if (adc_if.ready_i) begin
            r_valid <= 1'b0;
            if (!cfg_en_i) begin
              r_mask  <= '0;
              r_state <= IDLE;
            end else if (|r_mask) begin
              r_state <= SELECT;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = (r_state == SELECT) || (r_state == CONVERT) || (r_state == PUSH);
  // A trigger landing in a busy cycle is dropped and flagged in that same cycle
  assign overrun_o = w_tick & busy_o & ~rst_i;

  assign adc_if.adc_req_o = r_req;
  assign adc_if.adc_ch_o  = r_ch;
  assign adc_if.valid_o   = r_valid;
  assign adc_if.data_o    = r_data;

endmodule

// File: tb/tb_udma_adc_ch_sched.sv
// Bench for udma_adc_ch_sched: directed scenarios plus a randomized phase,
// all compared cycle by cycle against a scan-level reference model.
module tb_udma_adc_ch_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  mask;
  logic [15:0] period;
  logic        busy;
  logic        overrun;

  udma_adc_ch_sched_if #(.CH_W(2), .DATA_W(12)) bus ();

  udma_adc_ch_sched #(
    .NUM_CH(4), .CH_W(2), .DATA_W(12), .PERIOD_W(16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_en_i     (en),
    .cfg_ch_mask_i(mask),
    .cfg_period_i (period),
    .adc_if       (bus),
    .busy_o       (busy),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  // scenario-side requested inputs, applied at the next falling edge
  logic        s_rst;
  logic        s_en;
  logic [3:0]  s_mask;
  logic [15:0] s_period;
  int          ready_mode;  // 0: hold low, 1: hold high, 2: random
  int          ack_delay;
  int          ack_wait;
  bit          noise;

  int checks = 0;
  int errors = 0;

  // reference model: a scan is a queue of channels; each channel goes
  // through pick -> converting -> delivering
  localparam int PH_NONE = 0, PH_PICK = 1, PH_CONV = 2, PH_DLVR = 3;
  int          m_phase;
  bit          m_enabled;
  int          m_cnt;
  int          m_todo[$];
  int          m_ch;
  logic [31:0] m_word;

  logic [31:0] got[$];
  int n_ovr, n_req, n_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_drop_scan();
    m_todo.delete();
    m_phase   = PH_NONE;
    m_enabled = 1'b0;
  endtask

  task automatic model_step();
    bit tick;
    if (s_rst) begin
      m_phase = PH_NONE; m_enabled = 1'b0; m_cnt = 0;
      m_todo.delete(); m_ch = 0; m_word = '0;
      return;
    end
    tick  = s_en && (m_cnt >= int'(s_period));
    m_cnt = (!s_en || tick) ? 0 : m_cnt + 1;
    case (m_phase)
      PH_NONE: begin
        if (!m_enabled) begin
          if (s_en) m_enabled = 1'b1;
        end else if (!s_en) begin
          m_enabled = 1'b0;
        end else if (tick && s_mask != 4'd0) begin
          m_todo.delete();
          for (int c = 0; c < 4; c++) if (s_mask[c]) m_todo.push_back(c);
          m_phase = PH_PICK;
        end
      end
      PH_PICK: begin
        if (!s_en) model_drop_scan();
        else begin
          m_ch    = m_todo.pop_front();
          m_phase = PH_CONV;
        end
      end
      PH_CONV: begin
        if (bus.adc_ack_i) begin
          m_word  = (32'(m_ch) << 16) | 32'(bus.adc_data_i);
          m_phase = PH_DLVR;
        end
      end
      default: begin
        if (bus.ready_i) begin
          if (!s_en) model_drop_scan();
          else if (m_todo.size() != 0) m_phase = PH_PICK;
          else m_phase = PH_NONE;
        end
      end
    endcase
  endtask

  // one clock cycle: apply inputs, compare outputs with the model, advance it
  task automatic cyc();
    bit exp_busy, exp_ovr;
    @(negedge clk);
    rst    = s_rst;
    en     = s_en;
    mask   = s_mask;
    period = s_period;
    bus.ready_i = (ready_mode == 1) ? 1'b1 :
                  (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (m_phase == PH_CONV) begin
      ack_wait++;
      bus.adc_ack_i = (ack_wait >= ack_delay);
    end else begin
      ack_wait = 0;
      bus.adc_ack_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    bus.adc_data_i = 12'($urandom);
    #1;
    exp_busy = (m_phase != PH_NONE);
    exp_ovr  = !s_rst && exp_busy && s_en && (m_cnt >= int'(s_period));
    chk("adc_req", 32'(bus.adc_req_o), 32'(m_phase == PH_CONV));
    chk("adc_ch", 32'(bus.adc_ch_o), 32'(m_ch));
    chk("valid", 32'(bus.valid_o), 32'(m_phase == PH_DLVR));
    chk("data", bus.data_o, m_word);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    if (bus.valid_o && bus.ready_i) got.push_back(bus.data_o);
    if (overrun) n_ovr++;
    if (bus.adc_req_o) n_req++;
    if (busy) n_busy++;
    model_step();
  endtask

  task automatic clear_counts();
    got.delete();
    n_ovr = 0; n_req = 0; n_busy = 0;
  endtask

  initial begin
    int first_busy;
    int k;
    logic [31:0] held;

    s_rst = 1'b1; s_en = 1'b0; s_mask = '0; s_period = '0;
    ready_mode = 1; ack_delay = 3; ack_wait = 0; noise = 1'b0;
    rst = 1'b1; en = 1'b0; mask = '0; period = '0;
    bus.ready_i = 1'b0; bus.adc_ack_i = 1'b0; bus.adc_data_i = '0;
    m_phase = PH_NONE; m_enabled = 1'b0; m_cnt = 0; m_ch = 0; m_word = '0;

    // reset state
    repeat (3) cyc();
    s_rst = 1'b0;
    repeat (2) cyc();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_data", bus.data_o, 32'd0);

    // mask 1011, period 9, ack after 3 cycles: ch0, ch1, ch3
    clear_counts();
    s_mask = 4'b1011; s_period = 16'd9; ack_delay = 3; ready_mode = 1;
    s_en = 1'b1;
    first_busy = -1;
    k = 0;
    while (got.size() < 3 && k < 200) begin
      cyc();
      if (first_busy < 0 && busy) first_busy = k;
      k++;
    end
    chk("first_tick_cycle", 32'(first_busy), 32'd10);
    chk("scan1_words", 32'(got.size()), 32'd3);
    if (got.size() >= 3) begin
      chk("scan1_ch_a", got[0] >> 16, 32'd0);
      chk("scan1_ch_b", got[1] >> 16, 32'd1);
      chk("scan1_ch_c", got[2] >> 16, 32'd3);
    end
    s_en = 1'b0;
    repeat (4) cyc();

    // period 0: every tick during a scan is an overrun
    clear_counts();
    s_mask = 4'b0001; s_period = 16'd0; ack_delay = 2; s_en = 1'b1;
    repeat (60) cyc();
    chk("ovr_equals_busy", 32'(n_ovr), 32'(n_busy));
    chk("ovr_seen", 32'(n_ovr > 0), 32'd1);
    foreach (got[i]) chk("p0_word_ch", got[i] >> 16, 32'd0);
    s_en = 1'b0;
    repeat (8) cyc();

    // ready held low for 20 cycles in delivery
    clear_counts();
    s_mask = 4'b0110; s_period = 16'd20; ack_delay = 1; ready_mode = 0; s_en = 1'b1;
    for (int i = 0; i < 200 && m_phase != PH_DLVR; i++) cyc();
    chk("stall_reached", 32'(m_phase == PH_DLVR), 32'd1);
    held = m_word;
    n_req = 0;
    repeat (20) begin
      cyc();
      chk("stall_valid", 32'(bus.valid_o), 32'd1);
      chk("stall_data", bus.data_o, held);
    end
    chk("stall_no_req", 32'(n_req), 32'd0);
    ready_mode = 1;
    for (int i = 0; i < 100 && got.size() < 2; i++) cyc();
    chk("stall_words", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      chk("stall_ch_a", got[0] >> 16, 32'd1);
      chk("stall_ch_b", got[1] >> 16, 32'd2);
    end
    s_en = 1'b0;
    repeat (4) cyc();

    // zero mask: no activity at all
    clear_counts();
    s_mask = 4'b0000; s_period = 16'd3; s_en = 1'b1;
    repeat (50) cyc();
    chk("zmask_req", 32'(n_req), 32'd0);
    chk("zmask_ovr", 32'(n_ovr), 32'd0);
    chk("zmask_busy", 32'(n_busy), 32'd0);
    s_en = 1'b0;
    repeat (2) cyc();

    // disable while converting ch1 of a full-mask scan
    clear_counts();
    s_mask = 4'b1111; s_period = 16'd50; ack_delay = 3; s_en = 1'b1;
    for (int i = 0; i < 200 && !(m_phase == PH_CONV && m_ch == 1); i++) cyc();
    chk("dis_reached", 32'(m_phase == PH_CONV && m_ch == 1), 32'd1);
    s_en = 1'b0;
    repeat (20) cyc();
    chk("dis_words", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      chk("dis_ch_a", got[0] >> 16, 32'd0);
      chk("dis_ch_b", got[1] >> 16, 32'd1);
    end
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_req", 32'(bus.adc_req_o), 32'd0);

    // reset while a word is pending
    clear_counts();
    s_mask = 4'b0001; s_period = 16'd5; ready_mode = 0; s_en = 1'b1;
    for (int i = 0; i < 100 && m_phase != PH_DLVR; i++) cyc();
    chk("rst_reached", 32'(m_phase == PH_DLVR), 32'd1);
    s_rst = 1'b1;
    cyc();
    s_rst = 1'b0;
    cyc();
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_req", 32'(bus.adc_req_o), 32'd0);
    chk("rst_data", bus.data_o, 32'd0);
    chk("rst_ch", 32'(bus.adc_ch_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    ready_mode = 1;
    s_en = 1'b0;
    repeat (3) cyc();

    // randomized traffic against the model
    s_en = 1'b1; s_mask = 4'hF; s_period = 16'd3; ready_mode = 2; noise = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 49) == 0) s_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) s_mask = 4'($urandom);
      if ($urandom_range(0, 99) == 0) s_period = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) ack_delay = $urandom_range(1, 4);
      s_rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    s_rst = 1'b0; s_en = 1'b0; noise = 1'b0; ready_mode = 1;
    repeat (10) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
